// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler: merges debounced button pulses and gravity ticks into one board command stream.
// Latency: pulse sampled at edge k -> cmd_valid after edge k+1; one IDLE cycle separates commands.
// Backpressure: cmd_valid/cmd_code hold until cmd_ack; new pulses merge into per-source pending bits.
// Optional: define CMD_TIMEOUT_EN to abandon unacked commands after TIMEOUT cycles (adds err_timeout).
module tetris_move_scheduler #(
  parameter int PERIOD_L0 = 100_000_000,
  parameter int PERIOD_L1 = 50_000_000,
  parameter int PERIOD_L2 = 25_000_000,
  parameter int CNT_W     = 27,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       game_over,
  input  logic [1:0] velocity,
  input  logic       rot_cw,
  input  logic       rot_ccw,
  input  logic       move_l,
  input  logic       move_r,
  input  logic       soft_dn,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ack,
  input  logic       cmd_ok,
  output logic       lock_req,
  input  logic       spawn_done,
  output logic       busy
`ifdef CMD_TIMEOUT_EN
  ,
  output logic       err_timeout
`endif
);

  typedef enum logic [1:0] {HALT, IDLE, ISSUE, LOCK} state_t;

  // Command codes double as pending-bit indices.
  localparam logic [2:0] C_LEFT  = 3'd1;
  localparam logic [2:0] C_RIGHT = 3'd2;
  localparam logic [2:0] C_ROTCW = 3'd3;
  localparam logic [2:0] C_ROTCC = 3'd4;
  localparam logic [2:0] C_SOFT  = 3'd5;
  localparam logic [2:0] C_GRAV  = 3'd6;

  localparam logic [CNT_W-1:0] P0_M1 = CNT_W'(PERIOD_L0 - 1);
  localparam logic [CNT_W-1:0] P1_M1 = CNT_W'(PERIOD_L1 - 1);
  localparam logic [CNT_W-1:0] P2_M1 = CNT_W'(PERIOD_L2 - 1);

  state_t           state_q, state_d;
  logic [6:1]       pend_q, pend_d, issued_oh, set_vec;
  logic [2:0]       code_q, code_d, sel_code;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic             lock_first_q;
  logic             running, tick, halt_req, fall_cmd, timeout_hit;

  assign halt_req = !enable || game_over;
  assign running  = (state_q == IDLE) || (state_q == ISSUE);
  assign tick     = running && (cnt_q >= period_m1);
  assign fall_cmd = (code_q == C_GRAV) || (code_q == C_SOFT);

`ifdef CMD_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT + 1);
  logic [WT_W-1:0] wait_q;
  logic            err_q;

  assign timeout_hit = (state_q == ISSUE) && !cmd_ack && (wait_q == WT_W'(TIMEOUT - 1));
  assign err_timeout = err_q;

  // Cycles spent in the current ISSUE visit, plus the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= (state_q == ISSUE && state_d == ISSUE) ? wait_q + WT_W'(1) : '0;
      if (timeout_hit && !halt_req) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Gravity period for the live velocity; 2'b11 shares the slowest period.
  always_comb begin
    case (velocity)
      2'b01:   period_m1 = P1_M1;
      2'b10:   period_m1 = P2_M1;
      default: period_m1 = P0_M1;
    endcase
  end

  // Highest-priority pending source: gravity > rot cw > rot ccw > left > right > soft down.
  always_comb begin
    sel_code = 3'd0;
    if      (pend_q[6]) sel_code = C_GRAV;
    else if (pend_q[3]) sel_code = C_ROTCW;
    else if (pend_q[4]) sel_code = C_ROTCC;
    else if (pend_q[1]) sel_code = C_LEFT;
    else if (pend_q[2]) sel_code = C_RIGHT;
    else if (pend_q[5]) sel_code = C_SOFT;
  end

  // One-hot of the command currently on the port, used to retire its pending bit.
  always_comb begin
    issued_oh = '0;
    for (int i = 1; i <= 6; i++) issued_oh[i] = (code_q == 3'(i));
  end

  // Next state and registered-state outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT:    state_d = IDLE;
      IDLE:    if (|pend_q) state_d = ISSUE;
      ISSUE: begin
        if (cmd_ack)          state_d = (!cmd_ok && fall_cmd) ? LOCK : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      LOCK:    if (spawn_done) state_d = IDLE;
      default: state_d = HALT;
    endcase
    if (halt_req) state_d = HALT;

    cmd_valid = (state_q == ISSUE);
    cmd_code  = (state_q == ISSUE) ? code_q : 3'd0;
    lock_req  = (state_q == LOCK) && lock_first_q;
    busy      = (state_q == ISSUE) || (state_q == LOCK);
  end

  // Pending bits, gravity counter and latched command code; sets win over the ack clear.
  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    set_vec = {tick, soft_dn, rot_ccw, rot_cw, move_r, move_l};
    if (state_q == IDLE && state_d == ISSUE) code_d = sel_code;
    if (running) begin
      if (state_q == ISSUE && (cmd_ack || timeout_hit)) pend_d = pend_q & ~issued_oh;
      pend_d = pend_d | set_vec;
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      if (state_q == ISSUE && cmd_ack && cmd_ok && code_q == C_SOFT) cnt_d = '0;
    end
    if (state_d == HALT || state_d == LOCK) begin
      pend_d = '0;
      cnt_d  = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HALT;
      pend_q       <= '0;
      cnt_q        <= '0;
      code_q       <= 3'd0;
      lock_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      lock_first_q <= (state_d == LOCK) && (state_q != LOCK);
    end
  end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: vector table, directed multi-cycle sequences, randomized run vs model.
module tb_tetris_move_scheduler;

  localparam int TMO = 8;
  localparam int MH = 0, MI = 1, MS = 2, ML = 3;

  logic       clk = 1'b0;
  logic       reset, enable, game_over;
  logic [1:0] velocity;
  logic       rot_cw, rot_ccw, move_l, move_r, soft_dn;
  logic       cmd_valid, cmd_ack, cmd_ok, lock_req, spawn_done, busy;
  logic [2:0] cmd_code;
  logic       dut_err;

`ifdef CMD_TIMEOUT_EN
  logic err_timeout;
  assign dut_err = err_timeout;
`else
  assign dut_err = 1'b0;
`endif

  tetris_move_scheduler #(
    .PERIOD_L0(20), .PERIOD_L1(10), .PERIOD_L2(5), .CNT_W(27), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .game_over(game_over), .velocity(velocity),
    .rot_cw(rot_cw), .rot_ccw(rot_ccw), .move_l(move_l), .move_r(move_r), .soft_dn(soft_dn),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ack(cmd_ack), .cmd_ok(cmd_ok),
    .lock_req(lock_req), .spawn_done(spawn_done), .busy(busy)
`ifdef CMD_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural reference: pending set indexed by command code, priority walked as a list.
  int m_mode, m_code, m_cnt, m_wait;
  bit m_pend[1:6];
  bit m_lockfirst, m_err;
  int prio[6] = '{6, 3, 4, 1, 2, 5};

  function automatic int period_of(logic [1:0] v);
    case (v)
      2'b01:   return 10;
      2'b10:   return 5;
      default: return 20;
    endcase
  endfunction

  task automatic m_clear();
    for (int i = 1; i <= 6; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_edge();
    int  nm;
    bit  run, tk, restart;
    if (reset) begin
      m_mode = MH; m_clear(); m_cnt = 0; m_wait = 0; m_lockfirst = 0; m_err = 0; m_code = 0;
    end else if (!enable || game_over) begin
      m_mode = MH; m_clear(); m_cnt = 0; m_wait = 0; m_lockfirst = 0;
    end else begin
      run = (m_mode == MI) || (m_mode == MS);
      tk = run && (m_cnt >= period_of(velocity) - 1);
      nm = m_mode;
      restart = 0;
      case (m_mode)
        MH: nm = MI;
        MI: begin
          for (int i = 0; i < 6; i++)
            if (nm == MI && m_pend[prio[i]]) begin nm = MS; m_code = prio[i]; end
        end
        MS: begin
          if (cmd_ack) begin
            m_pend[m_code] = 1'b0;
            nm = (!cmd_ok && (m_code == 5 || m_code == 6)) ? ML : MI;
            restart = cmd_ok && (m_code == 5);
          end
`ifdef CMD_TIMEOUT_EN
          else if (m_wait == TMO - 1) begin
            m_pend[m_code] = 1'b0; m_err = 1'b1; nm = MI;
          end
`endif
        end
        default: if (spawn_done) nm = MI;
      endcase
      if (run) begin
        if (move_l)  m_pend[1] = 1'b1;
        if (move_r)  m_pend[2] = 1'b1;
        if (rot_cw)  m_pend[3] = 1'b1;
        if (rot_ccw) m_pend[4] = 1'b1;
        if (soft_dn) m_pend[5] = 1'b1;
        if (tk)      m_pend[6] = 1'b1;
        m_cnt = (tk || restart) ? 0 : m_cnt + 1;
      end
      if (nm == ML) begin m_clear(); m_cnt = 0; end
      m_lockfirst = (nm == ML) && (m_mode != ML);
      m_wait = (m_mode == MS && nm == MS) ? m_wait + 1 : 0;
      m_mode = nm;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic check_model(string tag);
    logic [6:0] act, exp;
    act = {cmd_valid, cmd_code, lock_req, busy, dut_err};
    exp = {m_mode == MS, (m_mode == MS) ? 3'(m_code) : 3'd0,
           m_mode == ML && m_lockfirst, m_mode == MS || m_mode == ML, m_err};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got v/code/lock/busy/err=%b want %b", tag, cyc, act, exp);
    end
  endtask

  task automatic check_int(string tag, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; game_over = 1'b0; velocity = 2'b00;
    {rot_cw, rot_ccw, move_l, move_r, soft_dn} = '0;
    cmd_ack = 1'b0; cmd_ok = 1'b0; spawn_done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Board that acks the Nth cycle of each offered command; records command starts seen on the port.
  int rises[$];
  int rise_codes[$];
  int lock_pulses;

  task automatic run_board(int n, int delay, bit ok);
    bit prev;
    for (int k = 0; k < n; k++) begin
      prev = cmd_valid;
      cmd_ack = (m_mode == MS) && (m_wait >= delay - 1);
      cmd_ok = ok;
      step();
      check_model("board");
      if (cmd_valid && !prev) begin rises.push_back(cyc); rise_codes.push_back(int'(cmd_code)); end
      if (lock_req) lock_pulses++;
    end
    cmd_ack = 1'b0;
  endtask

  // in: {reset, enable, rot_cw, move_l, move_r, soft_dn, cmd_ack, cmd_ok, spawn_done}
  // out: {cmd_valid, cmd_code, lock_req, busy} after the edge
  typedef struct packed { logic [8:0] in; logic [5:0] out; } vec_t;
  vec_t tbl[19];

  initial begin
    int base, vcount, codes_ok;
    bit found;

    tbl[0]  = '{9'b1_0_0000_000, 6'b0_000_0_0};
    tbl[1]  = '{9'b0_1_0000_000, 6'b0_000_0_0};
    tbl[2]  = '{9'b0_1_1100_000, 6'b0_000_0_0};
    tbl[3]  = '{9'b0_1_0000_000, 6'b1_011_0_1};
    tbl[4]  = '{9'b0_1_0000_110, 6'b0_000_0_0};
    tbl[5]  = '{9'b0_1_0000_000, 6'b1_001_0_1};
    tbl[6]  = '{9'b0_1_1000_000, 6'b1_001_0_1};
    tbl[7]  = '{9'b0_1_1000_100, 6'b0_000_0_0};
    tbl[8]  = '{9'b0_1_0000_000, 6'b1_011_0_1};
    tbl[9]  = '{9'b0_1_0000_110, 6'b0_000_0_0};
    tbl[10] = '{9'b0_1_0000_000, 6'b0_000_0_0};
    tbl[11] = '{9'b0_1_0010_000, 6'b0_000_0_0};
    tbl[12] = '{9'b0_1_0000_110, 6'b1_010_0_1};
    tbl[13] = '{9'b0_1_0001_110, 6'b0_000_0_0};
    tbl[14] = '{9'b0_1_0000_000, 6'b1_101_0_1};
    tbl[15] = '{9'b0_1_0000_100, 6'b0_000_1_1};
    tbl[16] = '{9'b0_1_0010_000, 6'b0_000_0_1};
    tbl[17] = '{9'b0_1_0000_001, 6'b0_000_0_0};
    tbl[18] = '{9'b0_1_0000_000, 6'b0_000_0_0};

    reset = 1'b1; enable = 1'b0; game_over = 1'b0; velocity = 2'b00;
    {rot_cw, rot_ccw, move_l, move_r, soft_dn} = '0;
    cmd_ack = 1'b0; cmd_ok = 1'b0; spawn_done = 1'b0;

    // Vector table: reset state, priority, merge, set-wins, stray ack, lock pulse, discard in LOCK.
    for (int r = 0; r < 19; r++) begin
      {reset, enable, rot_cw, move_l, move_r, soft_dn, cmd_ack, cmd_ok, spawn_done} = tbl[r].in;
      game_over = 1'b0; velocity = 2'b00; rot_ccw = 1'b0;
      step();
      n_checks++;
      if ({cmd_valid, cmd_code, lock_req, busy} !== tbl[r].out) begin
        n_errors++;
        $display("FAIL row%0d got v/code/lock/busy=%b want %b", r,
                 {cmd_valid, cmd_code, lock_req, busy}, tbl[r].out);
      end
    end
    check_int("reset_err", int'(dut_err), 0);

    // Gravity alone at velocity 0, board acks on the second cycle.
    do_reset();
    enable = 1'b1;
    rises.delete(); rise_codes.delete(); lock_pulses = 0;
    base = cyc;
    run_board(70, 2, 1'b1);
    check_int("grav_count", rises.size(), 3);
    if (rises.size() == 3) begin
      check_int("grav_first", rises[0] - base, 22);
      check_int("grav_gap1", rises[1] - rises[0], 20);
      check_int("grav_gap2", rises[2] - rises[1], 20);
      codes_ok = 1;
      foreach (rise_codes[i]) if (rise_codes[i] != 6) codes_ok = 0;
      check_int("grav_codes", codes_ok, 1);
    end
    check_int("grav_no_lock", lock_pulses, 0);

    // Velocity 0 -> 2 with the counter at 12.
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 13; k++) begin step(); check_model("vel_pre"); end
    velocity = 2'b10;
    rises.delete(); rise_codes.delete(); lock_pulses = 0;
    base = cyc;
    run_board(20, 1, 1'b1);
    check_int("vel_count", rises.size(), 4);
    if (rises.size() >= 3) begin
      check_int("vel_first", rises[0] - base, 2);
      check_int("vel_gap1", rises[1] - rises[0], 5);
      check_int("vel_gap2", rises[2] - rises[1], 5);
    end

    // Gravity blocked -> LOCK, discarded pulses, respawn, next tick 20 cycles on.
    do_reset();
    enable = 1'b1; velocity = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(); check_model("lock_wait");
      if (cmd_valid && cmd_code == 3'd6) found = 1'b1;
    end
    check_int("lock_grav_seen", int'(found), 1);
    cmd_ack = 1'b1; cmd_ok = 1'b0;
    step(); check_model("lock_enter");
    check_int("lock_req_first", int'(lock_req), 1);
    cmd_ack = 1'b0; move_r = 1'b1;
    step(); check_model("lock_hold");
    check_int("lock_req_second", int'(lock_req), 0);
    check_int("lock_busy", int'(busy), 1);
    step(); check_model("lock_hold2");
    move_r = 1'b0; spawn_done = 1'b1;
    step(); check_model("lock_spawn");
    spawn_done = 1'b0;
    rises.delete(); rise_codes.delete(); lock_pulses = 0;
    base = cyc;
    run_board(25, 1, 1'b1);
    check_int("respawn_cmds", rises.size(), 1);
    if (rises.size() >= 1) begin
      check_int("respawn_first", rises[0] - base, 21);
      check_int("respawn_code", rise_codes[0], 6);
    end

    // game_over mid-ISSUE, late ack, clean restart.
    do_reset();
    enable = 1'b1;
    step(); check_model("go_idle");
    move_l = 1'b1; step(); check_model("go_pulse");
    move_l = 1'b0; step(); check_model("go_issue");
    game_over = 1'b1; step(); check_model("go_halt");
    check_int("go_valid", int'(cmd_valid), 0);
    check_int("go_busy", int'(busy), 0);
    game_over = 1'b0; cmd_ack = 1'b1; cmd_ok = 1'b1;
    step(); check_model("go_late_ack");
    cmd_ack = 1'b0; step(); check_model("go_after");
    check_int("go_no_cmd", int'(cmd_valid), 0);
    enable = 1'b0; step(); check_model("go_dis");
    enable = 1'b1; step(); check_model("go_en");
    rot_ccw = 1'b1; step(); check_model("go_rot");
    rot_ccw = 1'b0; step(); check_model("go_rot_issue");
    check_int("go_restart_code", int'(cmd_code), 4);

`ifdef CMD_TIMEOUT_EN
    // Never-acked command is abandoned after TIMEOUT cycles; flag sticks until reset.
    do_reset();
    enable = 1'b1;
    step(); check_model("to_idle");
    soft_dn = 1'b1; step(); check_model("to_pulse");
    soft_dn = 1'b0;
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      step(); check_model("to_wait");
      if (cmd_valid) vcount++;
    end
    check_int("to_valid_cycles", vcount, TMO);
    check_int("to_err_set", int'(dut_err), 1);
    for (int k = 0; k < 5; k++) begin step(); check_model("to_sticky"); end
    check_int("to_err_hold", int'(dut_err), 1);
    do_reset();
    check_int("to_err_clear", int'(dut_err), 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 999) < 2);
      enable     = ($urandom_range(0, 99) < 97);
      game_over  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) velocity = 2'($urandom_range(0, 3));
      move_l     = ($urandom_range(0, 99) < 8);
      move_r     = ($urandom_range(0, 99) < 8);
      rot_cw     = ($urandom_range(0, 99) < 8);
      rot_ccw    = ($urandom_range(0, 99) < 8);
      soft_dn    = ($urandom_range(0, 99) < 8);
      cmd_ack    = (m_mode == MS) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
      cmd_ok     = ($urandom_range(0, 99) < 70);
      spawn_done = (m_mode == ML) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
      step();
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tetris_move_scheduler.md
Name: tetris_move_scheduler

Overview:
- Sequences all piece-motion commands into the board logic through one shared command port.
- Latches debounced button pulses and generates the gravity tick from the selected velocity level.
- Arbitrates requests and issues one command at a time on a valid/ack handshake.
- Tracks piece lock and respawn. Sits between the debouncers and game_screen in full_game; enable comes from the play-state clock enable.

Parameters:
- PERIOD_L0, 100_000_000, gravity period in clk cycles for velocity 2'b00 (and 2'b11).
- PERIOD_L1, 50_000_000, gravity period for velocity 2'b01.
- PERIOD_L2, 25_000_000, gravity period for velocity 2'b10.
- CNT_W, 27, gravity counter width; must hold PERIOD_L0-1.
- TIMEOUT, 1024, ack timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  play-state enable (clk_en_gs)
- game_over  in  1  board reports game over
- velocity  in  2  level select
- rot_cw, rot_ccw, move_l, move_r, soft_dn  in  1 each  single-cycle debounced pulses
- cmd_valid  out  1  command offered to board
- cmd_code  out  3  0 none, 1 left, 2 right, 3 rot cw, 4 rot ccw, 5 soft down, 6 gravity
- cmd_ack  in  1  one-cycle pulse from the board: command evaluated
- cmd_ok  in  1  sampled with cmd_ack; 1 = move applied, 0 = blocked
- lock_req  out  1  one-cycle pulse: lock piece, clear lines, spawn next
- spawn_done  in  1  one-cycle pulse: new piece placed
- busy  out  1  state is ISSUE or LOCK
- err_timeout  out  1  sticky timeout flag (port exists only with CMD_TIMEOUT_EN)

Behaviour:
- Reset: state HALT, all pending bits 0, gravity counter 0. cmd_valid=0, cmd_code=0, lock_req=0, busy=0, err_timeout=0.
- States: HALT, IDLE, ISSUE, LOCK.
  - HALT→IDLE when enable=1 and game_over=0.
  - From any state: enable=0 or game_over=1 → HALT next edge. This clears pendings and the counter, drops cmd_valid, and ignores stray acks.
- Pending bits, one per source (including gravity):
  - A pulse sets its bit at the sampling edge.
  - A pulse while the bit is already set merges; it is not counted twice.
  - Pulses arriving in HALT or LOCK are discarded.
- IDLE: if any bit is pending, the next edge enters ISSUE with cmd_valid=1 and cmd_code set to the highest-priority pending source. Priority: gravity > rot cw > rot ccw > left > right > soft down.
- ISSUE:
  - cmd_valid and cmd_code stay stable until cmd_ack.
  - On ack, the issued bit clears; a same-cycle new pulse for that source re-sets it (set wins). cmd_valid drops at the same edge.
  - Ack with cmd_ok=1 → IDLE. For soft down, it also restarts the gravity counter at 0.
  - Ack with cmd_ok=0 on gravity or soft down → LOCK. lock_req is high for exactly the first LOCK cycle, and all pendings clear.
  - Ack with cmd_ok=0 on any other command → IDLE; the command is simply dropped.
- LOCK: counter held at 0. spawn_done → IDLE.
- Latency:
  - Pulse sampled at edge k → cmd_valid=1 after edge k+1.
  - Ack at edge m → next command valid after edge m+1, because the controller spends one IDLE cycle between commands.
- Gravity counter:
  - Increments in IDLE and ISSUE.
  - When count ≥ period-1 for the current velocity: set the gravity pending bit and wrap to 0 on that edge.
  - A velocity change mid-count uses the new period immediately. A count already at or above the new period-1 ticks on the next edge.
  - A tick while gravity is already pending merges.
- Width: the counter compares unsigned at CNT_W bits. No overflow is possible given the comparison.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined: in ISSUE, a wait counter starts at 0 on entry. If TIMEOUT cycles elapse without cmd_ack:
  - the command is abandoned and its pending bit cleared;
  - state returns to IDLE;
  - err_timeout is set and stays set until reset.
- Undefined: ISSUE waits for ack indefinitely, and the err_timeout port is absent.

Test Plan:
- Parameters for this test: PERIOD_L0=20, PERIOD_L1=10, PERIOD_L2=5. Case: enable=1, velocity=0, no buttons, board acks ok after 2 cycles → cmd_code=6 appears every 20 cycles; lock_req never pulses.
- move_l and rot_cw pulsed on the same edge k → rot cw (3) valid after k+1 and acked; then left (1) issued after one IDLE cycle; both pendings end at 0.
- Gravity acked with cmd_ok=0 → lock_req high exactly 1 cycle; move_r pulses during LOCK produce no command; spawn_done returns to IDLE, and the next gravity tick comes 20 cycles later.
- velocity switched from 0 to 2 with the counter at 12 → gravity pending set on the next edge, then every 5 cycles.
- game_over asserted mid-ISSUE → cmd_valid=0 next cycle, state HALT; a late cmd_ack is ignored; enable toggle with game_over=0 restarts cleanly.
- CMD_TIMEOUT_EN with TIMEOUT=8: cmd never acked → cmd_valid drops after 8 cycles and err_timeout=1 holds until reset.
